// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: FSM state encoding and
// default sizing constants, also used by the bench to decode state_o.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/input_conditioner_sync.sv
// Multi-flop synchronizer for asynchronous inputs; q is the last stage.
// Shared by other lab blocks that take raw external signals.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces a raw button, producing a clean registered
// level plus one-cycle rise/fall pulses.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       db_level,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [1:0] state_o
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_btnS;
  state_t           r_state, w_nextState;
  logic [CNT_W-1:0] r_cnt, w_nextCnt;
  logic             r_level, w_nextLevel;
  logic             r_rise, w_rise;
  logic             r_fall, w_fall;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (w_btnS)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_level <= w_nextLevel;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
    end
  end

  // The counter holds how many consecutive opposite-level samples were seen;
  // the sample that reaches DEBOUNCE_CYCLES commits the new level.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextLevel = r_level;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (w_btnS) begin
          w_nextState = WAIT_HIGH;
          w_nextCnt   = CNT_ONE;
        end else begin
          w_nextCnt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!w_btnS) begin
          w_nextState = IDLE_LOW;
          w_nextCnt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_nextState = IDLE_HIGH;
          w_nextCnt   = '0;
          w_nextLevel = 1'b1;
          w_rise      = 1'b1;
        end else begin
          w_nextCnt   = r_cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!w_btnS) begin
          w_nextState = WAIT_LOW;
          w_nextCnt   = CNT_ONE;
        end else begin
          w_nextCnt   = '0;
        end
      end
      WAIT_LOW: begin
        if (w_btnS) begin
          w_nextState = IDLE_HIGH;
          w_nextCnt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_nextState = IDLE_LOW;
          w_nextCnt   = '0;
          w_nextLevel = 1'b0;
          w_fall      = 1'b1;
        end else begin
          w_nextCnt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_nextState = IDLE_LOW;
        w_nextCnt   = '0;
      end
    endcase
  end

  assign db_level   = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign state_o    = r_state;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench: a run-length reference model pushes expected
// {level, rise, fall, state} per edge; each test pops and compares.
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int S = DEF_SYNC_STAGES;
  localparam int D = DEF_DEBOUNCE_CYCLES;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       btn_in = 1'b0;
  logic       db_level;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [1:0] state_o;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [4:0] expQ[$];
  logic       mPipe[$];
  logic       mLevel;
  int         mRun;

  wire [4:0] obs = {db_level, rise_pulse, fall_pulse, state_o};

  input_conditioner #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .db_level   (db_level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // Reference: level flips once D consecutive delayed samples disagree with it.
  task automatic modelReset();
    mLevel = 1'b0;
    mRun   = 0;
    mPipe.delete();
    expQ.delete();
    for (int i = 0; i < S; i++) mPipe.push_back(1'b0);
  endtask

  task automatic modelStep(input logic b);
    logic   v;
    logic   r;
    logic   f;
    state_t st;
    v = mPipe.pop_front();
    mPipe.push_back(b);
    r = 1'b0;
    f = 1'b0;
    if (v !== mLevel) begin
      mRun++;
      if (mRun == D) begin
        mLevel = v;
        mRun   = 0;
        r      = v;
        f      = ~v;
      end
    end else begin
      mRun = 0;
    end
    if (mLevel) st = (mRun != 0) ? WAIT_LOW : IDLE_HIGH;
    else        st = (mRun != 0) ? WAIT_HIGH : IDLE_LOW;
    expQ.push_back({mLevel, r, f, st});
  endtask

  // Drive on the falling edge, leave the bench 1 time unit after the rising edge.
  task automatic applyStimulus(input logic b);
    @(negedge clk);
    btn_in = b;
    modelStep(b);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] exp;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1);
      exp = expQ.pop_front();
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL reset_pre cyc%0d: got lvl/rise/fall/st=%b required %b", i, obs, exp);
      end
    end
    #2 reset = 1'b1;
    #1;
    testsRun++;
    if (obs !== 5'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: got %b required %b", obs, 5'b0);
    end
    @(posedge clk);
    #1;
    testsRun++;
    if (obs !== 5'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_held: got %b required %b", obs, 5'b0);
    end
    #2 reset = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0);
      exp = expQ.pop_front();
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL reset_post cyc%0d: got %b required %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [4:0] exp;
    int         riseCount = 0;
    int         riseEdge  = -1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1);
      exp = expQ.pop_front();
      if (rise_pulse === 1'b1) begin
        riseCount++;
        riseEdge = i;
      end
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL press edge%0d: got lvl/rise/fall/st=%b required %b", i, obs, exp);
      end
    end
    testsRun++;
    if (riseCount !== 1 || riseEdge !== S + D) begin
      testsFailed++;
      $display("[TB] FAIL press_latency: got %0d rises at edge %0d required 1 at edge %0d",
               riseCount, riseEdge, S + D);
    end
    testsRun++;
    if (state_o !== IDLE_HIGH) begin
      testsFailed++;
      $display("[TB] FAIL press_state: got %0d required %0d", state_o, IDLE_HIGH);
    end
  endtask

  task automatic test_clean_release();
    logic [4:0] exp;
    int         fallCount = 0;
    int         fallEdge  = -1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0);
      exp = expQ.pop_front();
      if (fall_pulse === 1'b1) begin
        fallCount++;
        fallEdge = i;
      end
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL release edge%0d: got %b required %b", i, obs, exp);
      end
    end
    testsRun++;
    if (fallCount !== 1 || fallEdge !== S + D) begin
      testsFailed++;
      $display("[TB] FAIL release_latency: got %0d falls at edge %0d required 1 at edge %0d",
               fallCount, fallEdge, S + D);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] exp;
    logic       pattern [9];
    int         riseCount = 0;
    pattern = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(pattern[i]);
      exp = expQ.pop_front();
      if (rise_pulse === 1'b1) riseCount++;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL bounce cyc%0d: got %b required %b", i, obs, exp);
      end
    end
    testsRun++;
    if (riseCount !== 0 || db_level !== 1'b0 || state_o !== IDLE_LOW) begin
      testsFailed++;
      $display("[TB] FAIL bounce_reject: got rises=%0d lvl=%b st=%0d required 0/0/0",
               riseCount, db_level, state_o);
    end
  endtask

  task automatic test_release_bounce();
    logic [4:0] exp;
    logic       pattern [21];
    int         fallCount = 0;
    int         fallEdge  = -1;
    for (int i = 0; i < 10; i++) pattern[i] = 1'b1;
    pattern[10] = 1'b0;
    pattern[11] = 1'b0;
    pattern[12] = 1'b1;
    for (int i = 13; i < 21; i++) pattern[i] = 1'b0;
    for (int i = 0; i < 21; i++) begin
      applyStimulus(pattern[i]);
      exp = expQ.pop_front();
      if (fall_pulse === 1'b1) begin
        fallCount++;
        fallEdge = i - 12;
      end
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL rel_bounce cyc%0d: got %b required %b", i, obs, exp);
      end
    end
    testsRun++;
    if (fallCount !== 1 || fallEdge !== S + D) begin
      testsFailed++;
      $display("[TB] FAIL rel_bounce_fall: got %0d falls at edge %0d after bounce required 1 at %0d",
               fallCount, fallEdge, S + D);
    end
  endtask

  task automatic test_reset_during_wait();
    logic [4:0] exp;
    int         riseEdge = -1;
    for (int i = 0; i < S + D - 1; i++) begin
      applyStimulus(1'b1);
      exp = expQ.pop_front();
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL wait_pre cyc%0d: got %b required %b", i, obs, exp);
      end
    end
    testsRun++;
    if (state_o !== WAIT_HIGH) begin
      testsFailed++;
      $display("[TB] FAIL wait_state: got %0d required %0d", state_o, WAIT_HIGH);
    end
    #2 reset = 1'b1;
    #1;
    testsRun++;
    if (obs !== 5'b0) begin
      testsFailed++;
      $display("[TB] FAIL wait_reset: got %b required %b", obs, 5'b0);
    end
    @(posedge clk);
    #1;
    testsRun++;
    if (rise_pulse !== 1'b0 || db_level !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wait_lost_pulse: got rise=%b lvl=%b required 0/0", rise_pulse, db_level);
    end
    #2 reset = 1'b0;
    modelReset();
    for (int i = 1; i <= 12 && riseEdge < 0; i++) begin
      applyStimulus(1'b1);
      exp = expQ.pop_front();
      if (rise_pulse === 1'b1) riseEdge = i;
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL wait_post edge%0d: got %b required %b", i, obs, exp);
      end
    end
    testsRun++;
    if (riseEdge !== S + D) begin
      testsFailed++;
      $display("[TB] FAIL wait_rerise: got rise at edge %0d required %0d", riseEdge, S + D);
    end
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    test_reset();
    test_clean_press();
    test_clean_release();
    test_bounce();
    test_release_bounce();
    test_reset_during_wait();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
